spart_core: RTL and testbench
=============================

Name: spart_core

Overview:
- Bus-side responder and serial engine of the SPART (special-purpose async receiver/transmitter).
- Answers the processor-side driver's 8-bit bus cycles (iocs/iorw/ioaddr/databus).
- Holds the baud divisor, and transmits/receives 8N1 serial frames on txd/rxd.
- Sits between the driver FSM and the board UART pins.

Parameters:
- RST_DIV, 16'd5208: divisor loaded at reset; clocks per bit (9600 baud at 50 MHz).
- MIN_DIV, 16'd16: smallest effective divisor; smaller written values are clamped to this.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; asynchronous, active-high
- iocs  in  1  chip select
- iorw  in  1  1 = read, 0 = write
- ioaddr  in  2  register address
- databus  inout  8  bidirectional data
- rda  out  1  receive data available
- tbr  out  1  transmit buffer ready (empty)
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous

Behaviour:
- Register map:
  - 00: write = TX buffer; read = RX buffer.
  - 01: read = status {6'b0, tbr, rda}; writes ignored.
  - 10: DB low byte.
  - 11: DB high byte. Reads of 10/11 return the divisor byte.
- Bus: databus is driven combinationally only when iocs & iorw; otherwise 8'bz. Writes are captured on the rising clk edge with iocs & ~iorw. No wait states.
- Reset values: txd=1, tbr=1, rda=0, databus=z, divisor=RST_DIV, RX buffer=8'h00, both FSMs IDLE.
- Divisor: effective div = max(divisor, MIN_DIV). A new value takes effect at the next bit-counter reload; a frame in flight finishes with its old divisor.
- TX buffer:
  - A write to 00 with tbr=1 loads the buffer; tbr=0 from the next cycle.
  - A write with tbr=0 is dropped and the buffer is unchanged.
- TX FSM: IDLE, START, DATA, STOP.
  - IDLE→START when the buffer is full. The buffer moves to the shifter and tbr=1 in the same cycle.
  - START drives txd=0 for div clocks.
  - DATA shifts 8 bits LSB first, div clocks each.
  - STOP drives txd=1 for div clocks.
  - STOP→START directly if the buffer is full again; else →IDLE.
  - Back-to-back frames have no idle gap.
- RX: rxd passes through a 2-flop synchronizer.
- RX FSM: IDLE, START, DATA, STOP.
  - IDLE→START on a synced 1→0 transition.
  - START waits div/2 (integer truncation). If rxd=1 there, the edge was a glitch: →IDLE. Else →DATA.
  - DATA samples 8 bits, one every div clocks, LSB first.
  - STOP samples after div clocks:
    - 1: load RX buffer, rda=1.
    - 0: framing error; byte discarded.
  - STOP→IDLE in both cases.
- rda clear: rda clears on the clock edge of a read of 00 (iocs & iorw & ioaddr==00). If a new byte completes in that same cycle, set wins: rda=1 with the new byte.
- Overrun: a new byte overwrites the unread buffer; rda stays 1.
- Simultaneous TX write and TX shifter transfer in one cycle: the write is dropped, since tbr is still 0 in that cycle.
- Reset mid-frame: txd goes to 1 immediately; a partial RX frame is discarded.

Optional Feature:
- SPART_ERR_STATUS_EN defined:
  - Status bits [2] = framing error and [3] = overrun, both sticky.
  - Both clear on a status read (ioaddr 01).
- SPART_ERR_STATUS_EN undefined: those bits read 0 and no error flops exist.

Decomposition:
- spart_pkg holds:
  - address constants ADDR_DATA/ADDR_STAT/ADDR_DBL/ADDR_DBH;
  - the tx_state_t and rx_state_t enums;
  - the 9600/19200/38400/76800 divisor constants (5208/2604/1302/651).
- One sub-module, spart_rx: synchronizer, RX FSM, RX buffer, rda.
- TX, divisor and bus decode stay in spart_core.

Test Plan:
- Reset, then read 01 → databus=8'h02 (tbr=1, rda=0); txd=1; read 10/11 → 8'h58/8'h14 (5208).
- Write DBL=8'h10, DBH=8'h00; write 00=8'h6D → tbr=0 for 1 cycle. txd shows 0,1,0,1,1,0,1,1,0,1 (start, LSB-first data, stop), each level 16 clocks.
- Loop txd→rxd with div=16; send 8'hA5 → rda=1 about 160 clocks later. Read 00 → 8'hA5, rda=0 the next cycle.
- With tbr=0, write 00=8'h11 → dropped. After the first frame, a second write of 8'h22 transmits 8'h22 back-to-back with no idle gap.
- rxd glitch low for 4 clocks with div=16 → RX returns to IDLE, rda stays 0. A frame with stop bit=0 → rda stays 0; with SPART_ERR_STATUS_EN, status bit 2=1.
- Two frames received without a read → rda=1, buffer holds the second byte; with SPART_ERR_STATUS_EN, status bit 3=1, cleared by the status read.

Source files
------------

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - SPART shared register addresses, FSM state types and baud divisors.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam logic [15:0] DIV_9600  = 16'd5208;
  localparam logic [15:0] DIV_19200 = 16'd2604;
  localparam logic [15:0] DIV_38400 = 16'd1302;
  localparam logic [15:0] DIV_76800 = 16'd651;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 receiver: synchronizer, RX FSM, RX buffer and rda.
// SPART_ERR_STATUS_EN adds frame_err/overrun event outputs.
module spart_rx
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] div,
  input  logic        rd_clr,
  output logic        rda,
  output logic [7:0]  rx_data
`ifdef SPART_ERR_STATUS_EN
  ,
  output logic        frame_err,
  output logic        overrun
`endif
);

  logic        s1, s2, s3;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [15:0] fdiv;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        done_ok;

  assign done_ok = (state == RX_STOP) && (cnt == 16'd0) && s2;

`ifdef SPART_ERR_STATUS_EN
  assign frame_err = (state == RX_STOP) && (cnt == 16'd0) && !s2;
  assign overrun   = done_ok && rda && !rd_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= 16'd0;
      fdiv    <= 16'd0;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
      rx_data <= 8'h00;
      rda     <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
      // A completing byte beats a same-cycle read clear.
      if (done_ok) begin
        rx_data <= shift;
        rda     <= 1'b1;
      end else if (rd_clr) begin
        rda <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          if (s3 && !s2) begin
            state <= RX_START;
            fdiv  <= div;
            cnt   <= (div >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (cnt == 16'd0) begin
            if (s2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              cnt     <= fdiv - 16'd1;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == 16'd0) begin
            shift <= {s2, shift[7:1]};
            cnt   <= fdiv - 16'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == 16'd0) state <= RX_IDLE;
          else cnt <= cnt - 16'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/spart_core.sv
// rtl/spart_core.sv - SPART bus responder, baud divisor and 8N1 transmitter.
// SPART_ERR_STATUS_EN adds sticky framing/overrun status bits [2]/[3].
module spart_core
  import spart_pkg::*;
#(
  parameter logic [15:0] RST_DIV = DIV_9600,
  parameter logic [15:0] MIN_DIV = 16'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  logic [15:0] divisor, eff_div, tx_div, tx_cnt;
  logic [7:0]  tx_buf, tx_shift, rx_data, rd_data, status;
  logic [2:0]  tx_bit;
  tx_state_t   tx_state;
  logic        wr_en, rd_en, tx_load;

  assign wr_en   = iocs & ~iorw;
  assign rd_en   = iocs & iorw;
  assign eff_div = (divisor < MIN_DIV) ? MIN_DIV : divisor;
  assign databus = rd_en ? rd_data : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor <= RST_DIV;
    end else if (wr_en && ioaddr == ADDR_DBL) begin
      divisor[7:0] <= databus;
    end else if (wr_en && ioaddr == ADDR_DBH) begin
      divisor[15:8] <= databus;
    end
  end

  // Shifter takes the buffer from IDLE, or straight from the end of STOP.
  assign tx_load = !tbr && ((tx_state == TX_IDLE) ||
                            (tx_state == TX_STOP && tx_cnt == 16'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tbr      <= 1'b1;
      txd      <= 1'b1;
      tx_buf   <= 8'h00;
      tx_shift <= 8'h00;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'd0;
      tx_bit   <= 3'd0;
    end else begin
      if (wr_en && ioaddr == ADDR_DATA && tbr) begin
        tx_buf <= databus;
        tbr    <= 1'b0;
      end
      if (tx_load) begin
        tx_state <= TX_START;
        tx_shift <= tx_buf;
        tbr      <= 1'b1;
        txd      <= 1'b0;
        tx_div   <= eff_div;
        tx_cnt   <= eff_div - 16'd1;
      end else if (tx_state != TX_IDLE && tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= tx_div - 16'd1;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= 3'd0;
          end
          TX_DATA: begin
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end
          end
          TX_STOP: tx_state <= TX_IDLE;
          TX_IDLE: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

`ifdef SPART_ERR_STATUS_EN
  logic fe_flag, ov_flag, frame_err, overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_flag <= 1'b0;
      ov_flag <= 1'b0;
    end else begin
      if (frame_err) fe_flag <= 1'b1;
      else if (rd_en && ioaddr == ADDR_STAT) fe_flag <= 1'b0;
      if (overrun) ov_flag <= 1'b1;
      else if (rd_en && ioaddr == ADDR_STAT) ov_flag <= 1'b0;
    end
  end

  assign status = {4'b0, ov_flag, fe_flag, tbr, rda};
`else
  assign status = {6'b0, tbr, rda};
`endif

  always_comb begin
    rd_data = 8'h00;
    case (ioaddr)
      ADDR_DATA: rd_data = rx_data;
      ADDR_STAT: rd_data = status;
      ADDR_DBL:  rd_data = divisor[7:0];
      ADDR_DBH:  rd_data = divisor[15:8];
    endcase
  end

  spart_rx u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .div       (eff_div),
    .rd_clr    (rd_en && ioaddr == ADDR_DATA),
    .rda       (rda),
    .rx_data   (rx_data)
`ifdef SPART_ERR_STATUS_EN
    ,
    .frame_err (frame_err),
    .overrun   (overrun)
`endif
  );

endmodule

// File: tb/tb_spart_core.sv
// tb/tb_spart_core.sv - Directed self-checking bench for spart_core.
module tb_spart_core;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst, iocs, iorw, rxd_drv, loop_en, bus_oe;
  logic [1:0] ioaddr;
  logic [7:0] bus_drv, v;
  wire  [7:0] databus;
  wire        rxd;
  logic       rda, tbr, txd;
  int         checks = 0;
  int         errors = 0;
  int         n;

`ifdef SPART_ERR_STATUS_EN
  localparam logic [7:0] EXP_STAT_OV = 8'h0B;
  localparam logic [7:0] EXP_STAT_FE = 8'h06;
`else
  localparam logic [7:0] EXP_STAT_OV = 8'h03;
  localparam logic [7:0] EXP_STAT_FE = 8'h02;
`endif

  assign databus = bus_oe ? bus_drv : 8'bz;
  assign rxd     = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart_core dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_drv = d; bus_oe = 1'b1;
    @(posedge clk);
    #1;
    iocs = 1'b0; iorw = 1'b1; bus_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(posedge clk);
    #1;
    iocs = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (16) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] tx_byte;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
    bus_drv = 8'h00; bus_oe = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_txd", txd, 1'b1);
    check("rst_tbr", tbr, 1'b1);
    check("rst_rda", rda, 1'b0);
    bus_read(ADDR_STAT, v); check("rst_status", v, 8'h02);
    bus_read(ADDR_DBL, v);  check("rst_dbl", v, 8'h58);
    bus_read(ADDR_DBH, v);  check("rst_dbh", v, 8'h14);
    bus_read(ADDR_DATA, v); check("rst_rxbuf", v, 8'h00);

    bus_write(ADDR_DBL, 8'h10);
    bus_write(ADDR_DBH, 8'h00);
    bus_read(ADDR_DBL, v); check("dbl_readback", v, 8'h10);

    // 6D transmit; the 11 write lands on the transfer edge and is dropped
    bus_write(ADDR_DATA, 8'h6D);
    check("tbr_after_write", tbr, 1'b0);
    bus_write(ADDR_DATA, 8'h11);
    check("tbr_drop_on_transfer", tbr, 1'b1);
    repeat (8) @(posedge clk); #1;
    check("tx_start_bit", txd, 1'b0);
    tx_byte = 8'h6D;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk); #1;
      check($sformatf("tx_6d_bit%0d", i), txd, tx_byte[i]);
    end
    repeat (16) @(posedge clk); #1;
    check("tx_stop_bit", txd, 1'b1);
    repeat (16) @(posedge clk); #1;
    check("dropped_not_sent", txd, 1'b1);
    check("tbr_idle", tbr, 1'b1);

    // loopback A5
    loop_en = 1'b1;
    repeat (20) @(posedge clk);
    bus_write(ADDR_DATA, 8'hA5);
    n = 0;
    while (!rda && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("loop_rda_set", rda, 1'b1);
    check("loop_latency", (n >= 140 && n <= 180), 1'b1);
    bus_read(ADDR_DATA, v);
    check("loop_rx_a5", v, 8'hA5);
    check("rda_clear_on_read", rda, 1'b0);

    // back-to-back 33 then 22, both received unread
    repeat (20) @(posedge clk);
    bus_write(ADDR_DATA, 8'h33);
    @(posedge clk); #1;
    bus_write(ADDR_DATA, 8'h22);
    check("b2b_tbr_full", tbr, 1'b0);
    repeat (151) @(posedge clk); #1;
    check("b2b_stop1", txd, 1'b1);
    repeat (8) @(posedge clk); #1;
    check("b2b_no_gap", txd, 1'b0);
    repeat (400) @(posedge clk); #1;
    check("overrun_rda", rda, 1'b1);
    bus_read(ADDR_STAT, v); check("overrun_status", v, EXP_STAT_OV);
    bus_read(ADDR_STAT, v); check("overrun_status_cleared", v, 8'h03);
    bus_read(ADDR_DATA, v); check("overrun_second_byte", v, 8'h22);
    check("overrun_rda_clear", rda, 1'b0);

    // glitch, framing error, then a good frame
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk) rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("glitch_rda", rda, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("framing_rda", rda, 1'b0);
    bus_read(ADDR_STAT, v); check("framing_status", v, EXP_STAT_FE);
    bus_read(ADDR_STAT, v); check("framing_status_cleared", v, 8'h02);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(posedge clk); #1;
    check("good_frame_rda", rda, 1'b1);
    bus_read(ADDR_DATA, v); check("good_frame_data", v, 8'h5A);

    // divisor below minimum clamps to 16
    bus_write(ADDR_DBL, 8'h05);
    bus_read(ADDR_DBL, v); check("dbl_raw_readback", v, 8'h05);
    bus_write(ADDR_DATA, 8'h01);
    repeat (16) @(posedge clk); #1;
    check("clamp_start_hold", txd, 1'b0);
    @(posedge clk); #1;
    check("clamp_bit0", txd, 1'b1);

    // asynchronous reset mid-frame
    repeat (16) @(posedge clk); #1;
    check("pre_reset_bit1", txd, 1'b0);
    #2 rst = 1'b1;
    #1 check("async_reset_txd", txd, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    check("post_reset_tbr", tbr, 1'b1);
    bus_read(ADDR_DBL, v); check("post_reset_dbl", v, 8'h58);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
